// File: rtl/ic_pkg.sv
// ic_pkg: shared types, sizes and pseudo-LRU helpers for the icache LRU block.
//  LINES / WAYS      : cache geometry (256 lines, 8 ways)
//  ic_line_t         : line index, ic_lru_t: one stored LRU word, ic_way_t: way number
//  plru_t            : the 7 live tree-node bits of an LRU word
//  ic_lru_state_e    : controller FSM states
//  plru_victim/touch : tree walk for victim selection and for marking a way as recently used
package ic_pkg;
  localparam int LINES     = 256;
  localparam int WAYS      = 8;
  localparam int PLRU_BITS = WAYS - 1;

  typedef logic [7:0]           ic_line_t;
  typedef logic [7:0]           ic_lru_t;
  typedef logic [2:0]           ic_way_t;
  typedef logic [PLRU_BITS-1:0] plru_t;

  typedef enum logic {INIT, RUN} ic_lru_state_e;

  // Node k has children 2k+1 (left) and 2k+2 (right); a 1 steers to the right.
  function automatic ic_way_t plru_victim(input plru_t s);
    logic [2:0] c1;
    logic [2:0] c2;
    logic [1:0] leaf;
    c1   = s[0] ? 3'd2 : 3'd1;
    // 2*c1+1 is {c1[1:0],1} for c1 in {1,2}; add the level-1 bit to pick the right child.
    c2   = {c1[1:0], 1'b1} + {2'b00, s[c1]};
    leaf = 2'(c2 - 3'd3);
    return {leaf, s[c2]};
  endfunction

  // Every node on the path to w is set to point away from w.
  function automatic plru_t plru_touch(input plru_t s, input ic_way_t w);
    plru_t      r;
    logic [2:0] n1;
    logic [2:0] n2;
    r     = s;
    n1    = 3'd1 + {2'b00, w[2]};
    n2    = 3'd3 + {1'b0, w[2:1]};
    r[0]  = ~w[2];
    r[n1] = ~w[1];
    r[n2] = ~w[0];
    return r;
  endfunction
endpackage

// File: rtl/ic_lru_ctrl_if.sv
// ic_lru_acc_if: lookup-result request and way response between the tag-compare
// stage (master) and the LRU controller (slave).
//  acc_valid/acc_ready : request handshake
//  acc_line            : line index of the lookup
//  acc_hit/acc_hit_way : hit flag and hit way (way ignored on miss)
//  rsp_valid/rsp_way   : one-cycle response with the hit or victim way
interface ic_lru_acc_if;
  import ic_pkg::*;

  logic     acc_valid;
  logic     acc_ready;
  ic_line_t acc_line;
  logic     acc_hit;
  ic_way_t  acc_hit_way;
  logic     rsp_valid;
  ic_way_t  rsp_way;

  modport master (
    output acc_valid, acc_line, acc_hit, acc_hit_way,
    input  acc_ready, rsp_valid, rsp_way
  );

  modport slave (
    input  acc_valid, acc_line, acc_hit, acc_hit_way,
    output acc_ready, rsp_valid, rsp_way
  );
endinterface

// File: rtl/ic_lru_ram.sv
// ic_lru_ram: behavioural model of the LRU storage, one ic_lru_t word per line.
//  rd_en/rd_line -> rd_data one cycle later (registered read)
//  wr_en/wr_line/wr_data : synchronous write
// A read of the line being written in the same cycle returns the new data;
// the controller relies on this for back-to-back accesses to one line.
// Contents have no reset.
module ic_lru_ram
  import ic_pkg::*;
(
  input  logic     clk,
  input  logic     rd_en,
  input  ic_line_t rd_line,
  output ic_lru_t  rd_data,
  input  logic     wr_en,
  input  ic_line_t wr_line,
  input  ic_lru_t  wr_data
);
  ic_lru_t mem [LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_line] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= (wr_en && (wr_line == rd_line)) ? wr_data : mem[rd_line];
    end
  end
endmodule

// File: rtl/ic_plru_tree.sv
// ic_plru_tree: combinational pseudo-LRU tree for 8 ways.
//  state_i     : current 7 node bits
//  touch_way_i : way to mark as most recently used
//  victim_o    : way the tree currently points at
//  new_state_o : node bits after touching touch_way_i
module ic_plru_tree
  import ic_pkg::*;
(
  input  plru_t   state_i,
  input  ic_way_t touch_way_i,
  output ic_way_t victim_o,
  output plru_t   new_state_o
);
  assign victim_o    = plru_victim(state_i);
  assign new_state_o = plru_touch(state_i, touch_way_i);
endmodule

// File: rtl/ic_lru_ctrl.sv
// ic_lru_ctrl: owns ic_lru_ram and keeps one pseudo-LRU tree per icache line.
//  clk, rst_n      : clock, asynchronous active-low reset
//  flush_req       : pulse, re-clear all LRU state (honoured in RUN only)
//  init_done       : clear sweep finished, accesses accepted
//  acc (slave)     : lookup results in, hit/victim way responses out
//  lru_rd_*        : RAM read port (1-cycle latency data on lru_rd_data)
//  lru_wr_*        : RAM write port
// Pipeline: T read, T+1 compute + write back, T+2 response.
module ic_lru_ctrl
  import ic_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_req,
  output logic         init_done,
  ic_lru_acc_if.slave  acc,
  output ic_line_t     lru_rd_line,
  output logic         lru_rd_en,
  input  ic_lru_t      lru_rd_data,
  output ic_line_t     lru_wr_line,
  output ic_lru_t      lru_wr_data,
  output logic         lru_wr_en
);
  localparam ic_line_t LAST_LINE = ic_line_t'(LINES - 1);

  ic_lru_state_e state_q, state_d;
  ic_line_t      cnt_q, cnt_d;
  logic          live_q, live_d;
  logic          flush_pend_q, flush_pend_d;
  logic          s1_valid_q, s1_valid_d;
  ic_line_t      s1_line_q, s1_line_d;
  logic          s1_hit_q, s1_hit_d;
  ic_way_t       s1_way_q, s1_way_d;
  logic          rsp_valid_q, rsp_valid_d;
  ic_way_t       rsp_way_q, rsp_way_d;

  logic    acc_ready;
  logic    accept;
  ic_way_t victim;
  ic_way_t touch_way;
  plru_t   new_state;
  logic    rd_msb_unused;

  // The top node bit of the stored word carries no tree information.
  assign rd_msb_unused = lru_rd_data[7];

  assign init_done     = (state_q == RUN);
  assign acc_ready     = init_done & ~flush_pend_q;
  assign accept        = acc.acc_valid & acc_ready;
  assign acc.acc_ready = acc_ready;
  assign acc.rsp_valid = rsp_valid_q;
  assign acc.rsp_way   = rsp_way_q;

  assign lru_rd_en   = accept;
  assign lru_rd_line = accept ? acc.acc_line : '0;

  // Hits refresh the hit way; misses refresh the victim they evict.
  assign touch_way = s1_hit_q ? s1_way_q : victim;

  ic_plru_tree u_tree (
    .state_i     (lru_rd_data[PLRU_BITS-1:0]),
    .touch_way_i (touch_way),
    .victim_o    (victim),
    .new_state_o (new_state)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    live_d       = 1'b1;
    flush_pend_d = flush_pend_q;
    lru_wr_en    = 1'b0;
    lru_wr_line  = '0;
    lru_wr_data  = '0;

    s1_valid_d  = accept;
    s1_line_d   = accept ? acc.acc_line    : s1_line_q;
    s1_hit_d    = accept ? acc.acc_hit     : s1_hit_q;
    s1_way_d    = accept ? acc.acc_hit_way : s1_way_q;
    rsp_valid_d = s1_valid_q;
    rsp_way_d   = s1_valid_q ? touch_way : rsp_way_q;

    case (state_q)
      INIT: begin
        // live_q holds the port quiet for the first cycle out of reset.
        if (live_q) begin
          lru_wr_en   = 1'b1;
          lru_wr_line = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_LINE) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush_req && !flush_pend_q) begin
          flush_pend_d = 1'b1;
        end
        // Leave only once the stage-1 write has drained; its response is
        // already registered and still leaves on the next cycle.
        if (flush_pend_q && !s1_valid_q) begin
          state_d      = INIT;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end
        if (s1_valid_q) begin
          lru_wr_en   = 1'b1;
          lru_wr_line = s1_line_q;
          lru_wr_data = {1'b0, new_state};
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      live_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_line_q    <= '0;
      s1_hit_q     <= 1'b0;
      s1_way_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_way_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      live_q       <= live_d;
      flush_pend_q <= flush_pend_d;
      s1_valid_q   <= s1_valid_d;
      s1_line_q    <= s1_line_d;
      s1_hit_q     <= s1_hit_d;
      s1_way_q     <= s1_way_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_way_q    <= rsp_way_d;
    end
  end
endmodule

// File: tb/tb_ic_lru_ctrl.sv
// tb_ic_lru_ctrl: directed self-checking bench for ic_lru_ctrl driving a
// behavioural ic_lru_ram. Inputs change on the falling edge; outputs are
// sampled on the falling edge (or 1 ns after a drive for combinational ones).
module tb_ic_lru_ctrl;
  import ic_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     flush_req;
  logic     init_done;
  ic_line_t lru_rd_line;
  logic     lru_rd_en;
  ic_lru_t  lru_rd_data;
  ic_line_t lru_wr_line;
  ic_lru_t  lru_wr_data;
  logic     lru_wr_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic_lru_acc_if acc_if ();

  ic_lru_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_req   (flush_req),
    .init_done   (init_done),
    .acc         (acc_if),
    .lru_rd_line (lru_rd_line),
    .lru_rd_en   (lru_rd_en),
    .lru_rd_data (lru_rd_data),
    .lru_wr_line (lru_wr_line),
    .lru_wr_data (lru_wr_data),
    .lru_wr_en   (lru_wr_en)
  );

  ic_lru_ram u_ram (
    .clk     (clk),
    .rd_en   (lru_rd_en),
    .rd_line (lru_rd_line),
    .rd_data (lru_rd_data),
    .wr_en   (lru_wr_en),
    .wr_line (lru_wr_line),
    .wr_data (lru_wr_data)
  );

  task automatic drive_acc(input ic_line_t line, input logic hit, input ic_way_t way);
    acc_if.acc_valid   = 1'b1;
    acc_if.acc_line    = line;
    acc_if.acc_hit     = hit;
    acc_if.acc_hit_way = way;
  endtask

  task automatic idle_acc();
    acc_if.acc_valid   = 1'b0;
    acc_if.acc_line    = '0;
    acc_if.acc_hit     = 1'b0;
    acc_if.acc_hit_way = '0;
  endtask

  // Observes a clear sweep until init_done rises (bounded); returns what it saw.
  task automatic watch_sweep(output bit done, output int nwr, output int bad,
                             output int rd_seen, output int rsp_seen,
                             output int rdy_seen, output bit last255);
    int  exp_line;
    bit  prev_was_255;
    done = 0; nwr = 0; bad = 0; rd_seen = 0; rsp_seen = 0; rdy_seen = 0; last255 = 0;
    exp_line = 0;
    prev_was_255 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        done    = 1;
        last255 = prev_was_255;
        break;
      end
      prev_was_255 = 0;
      if (lru_wr_en === 1'b1) begin
        if (lru_wr_line !== ic_line_t'(exp_line) || lru_wr_data !== 8'h00) bad++;
        prev_was_255 = (lru_wr_line === 8'd255);
        exp_line++;
        nwr++;
      end
      if (lru_rd_en !== 1'b0) rd_seen++;
      if (acc_if.rsp_valid !== 1'b0) rsp_seen++;
      if (acc_if.acc_ready !== 1'b0) rdy_seen++;
    end
    $display("sweep: writes=%0d bad=%0d rd=%0d rsp=%0d done=%0b", nwr, bad, rd_seen, rsp_seen, done);
  endtask

  task automatic test_reset();
    bit done, last255;
    int nwr, bad, rd_seen, rsp_seen, rdy_seen;
    rst_n = 1'b0; flush_req = 1'b0; idle_acc();
    repeat (3) @(negedge clk);
    checks++;
    if ({init_done, lru_wr_en, lru_rd_en, acc_if.rsp_valid, acc_if.acc_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: done/wr/rd/rsp/rdy=%b want 00000",
               {init_done, lru_wr_en, lru_rd_en, acc_if.rsp_valid, acc_if.acc_ready});
    end
    checks++;
    if ({lru_wr_line, lru_wr_data, lru_rd_line, acc_if.rsp_way} !== 27'b0) begin
      errors++;
      $display("FAIL reset_data: wr_line=%0d wr_data=%h rd_line=%0d rsp_way=%0d want all 0",
               lru_wr_line, lru_wr_data, lru_rd_line, acc_if.rsp_way);
    end
    rst_n = 1'b1;
    watch_sweep(done, nwr, bad, rd_seen, rsp_seen, rdy_seen, last255);
    checks++;
    if (!done || nwr != 256 || bad != 0) begin
      errors++;
      $display("FAIL reset_sweep: done=%0b writes=%0d bad=%0d want 1/256/0", done, nwr, bad);
    end
    checks++;
    if (rd_seen != 0 || rdy_seen != 0) begin
      errors++;
      $display("FAIL reset_sweep_rd: rd_en cycles=%0d ready cycles=%0d want 0/0", rd_seen, rdy_seen);
    end
    checks++;
    if (!last255) begin
      errors++;
      $display("FAIL reset_done_timing: init_done not right after line-255 write, got %0b want 1", last255);
    end
  endtask

  task automatic test_miss_seq();
    @(negedge clk); drive_acc(8'd5, 1'b0, 3'd0); #1;
    checks++;
    if (lru_rd_en !== 1'b1 || lru_rd_line !== 8'd5) begin
      errors++;
      $display("FAIL miss1_rd: rd_en=%0b rd_line=%0d want 1/5", lru_rd_en, lru_rd_line);
    end
    @(negedge clk); idle_acc();
    checks++;
    if (lru_wr_en !== 1'b1 || lru_wr_line !== 8'd5 || lru_wr_data !== 8'h0B) begin
      errors++;
      $display("FAIL miss1_wr: wr_en=%0b line=%0d data=%h want 1/5/0b", lru_wr_en, lru_wr_line, lru_wr_data);
    end
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL miss1_rsp: valid=%0b way=%0d want 1/0", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 5 miss -> rsp_way %0d", acc_if.rsp_way);
    drive_acc(8'd5, 1'b0, 3'd0);
    @(negedge clk); idle_acc();
    checks++;
    if (acc_if.rsp_valid !== 1'b0 || lru_wr_data !== 8'h2E || lru_wr_line !== 8'd5) begin
      errors++;
      $display("FAIL miss2_wr: rsp_valid=%0b line=%0d data=%h want 0/5/2e",
               acc_if.rsp_valid, lru_wr_line, lru_wr_data);
    end
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd4) begin
      errors++;
      $display("FAIL miss2_rsp: valid=%0b way=%0d want 1/4", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 5 miss -> rsp_way %0d", acc_if.rsp_way);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_acc(8'd9, 1'b0, 3'd0);
    @(negedge clk); drive_acc(8'd9, 1'b0, 3'd0); #1;
    checks++;
    if (lru_rd_en !== 1'b1 || lru_wr_en !== 1'b1 || lru_wr_line !== 8'd9 || lru_wr_data !== 8'h0B) begin
      errors++;
      $display("FAIL b2b_first_wr: rd_en=%0b wr_en=%0b line=%0d data=%h want 1/1/9/0b",
               lru_rd_en, lru_wr_en, lru_wr_line, lru_wr_data);
    end
    @(negedge clk); idle_acc();
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd0 || lru_wr_data !== 8'h2E) begin
      errors++;
      $display("FAIL b2b_rsp0: valid=%0b way=%0d wr_data=%h want 1/0/2e",
               acc_if.rsp_valid, acc_if.rsp_way, lru_wr_data);
    end
    $display("acc line 9 miss -> rsp_way %0d", acc_if.rsp_way);
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd4) begin
      errors++;
      $display("FAIL b2b_rsp1: valid=%0b way=%0d want 1/4", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 9 miss -> rsp_way %0d", acc_if.rsp_way);
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b0 || lru_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: rsp_valid=%0b wr_en=%0b want 0/0", acc_if.rsp_valid, lru_wr_en);
    end
  endtask

  task automatic test_hit();
    @(negedge clk); drive_acc(8'd3, 1'b1, 3'd7);
    @(negedge clk); drive_acc(8'd3, 1'b1, 3'd0);
    checks++;
    if (lru_wr_en !== 1'b1 || lru_wr_line !== 8'd3 || lru_wr_data !== 8'h00) begin
      errors++;
      $display("FAIL hit7_wr: wr_en=%0b line=%0d data=%h want 1/3/00", lru_wr_en, lru_wr_line, lru_wr_data);
    end
    @(negedge clk); idle_acc();
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd7 || lru_wr_data !== 8'h0B) begin
      errors++;
      $display("FAIL hit7_rsp: valid=%0b way=%0d wr_data=%h want 1/7/0b",
               acc_if.rsp_valid, acc_if.rsp_way, lru_wr_data);
    end
    $display("acc line 3 hit 7 -> rsp_way %0d", acc_if.rsp_way);
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL hit0_rsp: valid=%0b way=%0d want 1/0", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 3 hit 0 -> rsp_way %0d", acc_if.rsp_way);
  endtask

  task automatic test_flush();
    bit done, last255;
    int nwr, bad, rd_seen, rsp_seen, rdy_seen;
    @(negedge clk); drive_acc(8'd20, 1'b0, 3'd0); flush_req = 1'b1;
    @(negedge clk); idle_acc(); flush_req = 1'b0;
    checks++;
    if (acc_if.acc_ready !== 1'b0 || lru_wr_en !== 1'b1 || lru_wr_line !== 8'd20 || lru_wr_data !== 8'h0B) begin
      errors++;
      $display("FAIL flush_inflight: ready=%0b wr_en=%0b line=%0d data=%h want 0/1/20/0b",
               acc_if.acc_ready, lru_wr_en, lru_wr_line, lru_wr_data);
    end
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL flush_rsp: valid=%0b way=%0d want 1/0", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 20 miss -> rsp_way %0d", acc_if.rsp_way);
    watch_sweep(done, nwr, bad, rd_seen, rsp_seen, rdy_seen, last255);
    checks++;
    if (!done || nwr != 256 || bad != 0 || rdy_seen != 0) begin
      errors++;
      $display("FAIL flush_sweep: done=%0b writes=%0d bad=%0d ready=%0d want 1/256/0/0",
               done, nwr, bad, rdy_seen);
    end
    // Line 5 held 8'h2E before the flush; it must be clear again.
    drive_acc(8'd5, 1'b0, 3'd0);
    @(negedge clk); idle_acc();
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b1 || acc_if.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: valid=%0b way=%0d want 1/0", acc_if.rsp_valid, acc_if.rsp_way);
    end
    $display("acc line 5 miss -> rsp_way %0d", acc_if.rsp_way);
  endtask

  task automatic test_async_reset();
    bit done, last255;
    int nwr, bad, rd_seen, rsp_seen, rdy_seen;
    // Mid-sweep: start a sweep with a flush, then pull reset between edges.
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (lru_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL arst_presweep: wr_en=%0b want 1", lru_wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lru_wr_en !== 1'b0 || init_done !== 1'b0 || lru_wr_line !== 8'd0) begin
      errors++;
      $display("FAIL arst_sweep_out: wr_en=%0b done=%0b wr_line=%0d want 0/0/0", lru_wr_en, init_done, lru_wr_line);
    end
    @(negedge clk); rst_n = 1'b1;
    watch_sweep(done, nwr, bad, rd_seen, rsp_seen, rdy_seen, last255);
    checks++;
    if (!done || nwr != 256 || bad != 0) begin
      errors++;
      $display("FAIL arst_sweep_restart: done=%0b writes=%0d bad=%0d want 1/256/0", done, nwr, bad);
    end
    // Mid-access: reset while the access sits in stage 1.
    drive_acc(8'd7, 1'b0, 3'd0);
    @(negedge clk); idle_acc();
    checks++;
    if (lru_wr_en !== 1'b1 || lru_wr_line !== 8'd7) begin
      errors++;
      $display("FAIL arst_inflight: wr_en=%0b line=%0d want 1/7", lru_wr_en, lru_wr_line);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lru_wr_en !== 1'b0 || acc_if.rsp_valid !== 1'b0 || acc_if.acc_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_acc_out: wr_en=%0b rsp=%0b ready=%0b want 0/0/0",
               lru_wr_en, acc_if.rsp_valid, acc_if.acc_ready);
    end
    @(negedge clk);
    checks++;
    if (acc_if.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_no_rsp: rsp_valid=%0b want 0", acc_if.rsp_valid);
    end
    rst_n = 1'b1;
    watch_sweep(done, nwr, bad, rd_seen, rsp_seen, rdy_seen, last255);
    checks++;
    if (!done || nwr != 256 || bad != 0 || rsp_seen != 0) begin
      errors++;
      $display("FAIL arst_acc_restart: done=%0b writes=%0d bad=%0d rsp=%0d want 1/256/0/0",
               done, nwr, bad, rsp_seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush_req = 1'b0;
    idle_acc();
    test_reset();
    test_miss_seq();
    test_back_to_back();
    test_hit();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
